// File: rtl/uart_alu_pkg.sv
// Shared definitions for the ALU-to-UART result path.
// Holds the framer FSM state encoding, the default frame header byte and
// the helper that turns a result width into its byte count.
package uart_alu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWait,
    StDone
  } tx_state_e;

  localparam logic [7:0] DefaultHeader = 8'hA5;

  // Number of whole bytes carried by a result of nb_result bits.
  function automatic int unsigned result_bytes(input int unsigned nb_result);
    return nb_result / 8;
  endfunction

endpackage

// File: rtl/result_tx_framer.sv
// Frames ALU results for a byte-wide UART transmitter.
// Frame: HEADER, result bytes LSB first, then XOR checksum of all prior bytes.
// Ports:
//   i_clk, i_reset      - clock, synchronous active-high reset
//   i_result[_valid]    - result word and its one-cycle valid pulse
//   i_tx_done           - transmitter finished the current byte
//   o_tx_start/o_tx_data- one-cycle transmit request and the byte to send
//   o_busy              - not idle
//   o_frame_done        - one-cycle pulse after the checksum byte completes
//   o_overflow          - sticky: a result arrived with the pending slot full
module result_tx_framer
  import uart_alu_pkg::*;
#(
  parameter int unsigned NB_RESULT = 16,
  parameter logic [7:0]  HEADER    = DefaultHeader
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NB_RESULT-1:0] i_result,
  input  logic                 i_result_valid,
  input  logic                 i_tx_done,
  output logic                 o_tx_start,
  output logic [7:0]           o_tx_data,
  output logic                 o_busy,
  output logic                 o_frame_done,
  output logic                 o_overflow
);

  localparam int unsigned NBytes  = result_bytes(NB_RESULT);
  // Index 0 is the header, 1..NBytes the result bytes, NBytes+1 the checksum.
  localparam logic [2:0]  LastIdx = 3'(NBytes + 1);

  tx_state_e              state_q, state_d;
  logic [2:0]             idx_q, idx_d;
  logic [NB_RESULT-1:0]   active_q, active_d;
  logic [NB_RESULT-1:0]   pend_q, pend_d;
  logic                   pend_full_q, pend_full_d;
  logic                   overflow_q, overflow_d;
  logic [7:0]             checksum;
  logic [7:0]             byte_sel;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= StIdle;
      idx_q       <= 3'd0;
      active_q    <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      active_q    <= active_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      overflow_q  <= overflow_d;
    end
  end

  // Byte selection works only from the captured word, so the transmitted
  // data and checksum cannot follow a changing i_result.
  always_comb begin
    checksum = HEADER;
    for (int i = 0; i < NBytes; i++) begin
      checksum = checksum ^ active_q[8*i +: 8];
    end
    byte_sel = HEADER;
    for (int i = 0; i < NBytes; i++) begin
      if (idx_q == 3'(i + 1)) byte_sel = active_q[8*i +: 8];
    end
    if (idx_q == LastIdx) byte_sel = checksum;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    active_d    = active_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    overflow_d  = overflow_q;

    unique case (state_q)
      StIdle: begin
        if (i_result_valid) begin
          active_d = i_result;
          idx_d    = 3'd0;
          state_d  = StStart;
        end
      end
      StStart: state_d = StWait;
      StWait: begin
        if (i_tx_done) begin
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = StStart;
          end
        end
      end
      StDone: begin
        idx_d = 3'd0;
        if (pend_full_q) begin
          active_d    = pend_q;
          pend_full_d = 1'b0;
          state_d     = StStart;
        end else if (i_result_valid) begin
          // Empty slot in DONE: the new result goes straight to the active
          // register, equivalent to buffering it and draining it next cycle.
          active_d = i_result;
          state_d  = StStart;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_q != StIdle && i_result_valid) begin
      if (pend_full_q) begin
        overflow_d = 1'b1;
      end else if (state_q != StDone) begin
        pend_d      = i_result;
        pend_full_d = 1'b1;
      end
    end
  end

  assign o_tx_start   = (state_q == StStart);
  assign o_tx_data    = (state_q == StIdle) ? 8'h00 : byte_sel;
  assign o_busy       = (state_q != StIdle);
  assign o_frame_done = (state_q == StDone);
  assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_result_tx_framer.sv
module tb_result_tx_framer;

  logic        i_clk;
  logic        i_reset;
  logic [15:0] i_result;
  logic        i_result_valid;
  logic        i_tx_done;
  logic        o_tx_start;
  logic [7:0]  o_tx_data;
  logic        o_busy;
  logic        o_frame_done;
  logic        o_overflow;

  result_tx_framer #(
    .NB_RESULT(16),
    .HEADER   (8'hA5)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_result      (i_result),
    .i_result_valid(i_result_valid),
    .i_tx_done     (i_tx_done),
    .o_tx_start    (o_tx_start),
    .o_tx_data     (o_tx_data),
    .o_busy        (o_busy),
    .o_frame_done  (o_frame_done),
    .o_overflow    (o_overflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         done_cnt = 0;
  logic       start_armed = 1'b1;
  int         starts_seen = 0;
  int         frames = 0;
  logic       inject_in_start = 1'b0;
  logic       expect_chain = 1'b0;
  logic       prev_fd = 1'b0;
  logic [7:0] last_data = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [15:0] r);
    exp_q.push_back(8'hA5);
    exp_q.push_back(r[7:0]);
    exp_q.push_back(r[15:8]);
    exp_q.push_back(8'hA5 ^ r[7:0] ^ r[15:8]);
  endtask

  // One clock: sample #1 after the edge, clear pulses, run the tx model and
  // the scoreboard.
  task automatic tick();
    logic [7:0] exp_b;
    @(posedge i_clk);
    #1;
    i_result_valid = 1'b0;
    i_tx_done      = 1'b0;
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) begin
        i_tx_done   = 1'b1;
        start_armed = 1'b1;
      end
    end
    if (expect_chain && prev_fd) begin
      chk("chain_no_idle_gap", o_tx_start, 1);
      expect_chain = 1'b0;
    end
    if (o_tx_start) begin
      starts_seen++;
      chk("start_after_done", start_armed, 1);
      start_armed = 1'b0;
      if (exp_q.size() == 0) begin
        chk("unexpected_start", o_tx_start, 0);
      end else begin
        exp_b = exp_q.pop_front();
        chk("tx_byte", o_tx_data, exp_b);
      end
      last_data = o_tx_data;
      done_cnt  = 10;
      if (inject_in_start) begin
        i_tx_done       = 1'b1;
        inject_in_start = 1'b0;
      end
    end else if (o_busy && !o_frame_done) begin
      chk("wait_data_stable", o_tx_data, last_data);
    end
    if (o_frame_done) frames++;
    prev_fd = o_frame_done;
  endtask

  task automatic send(input logic [15:0] r);
    i_result       = r;
    i_result_valid = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((o_busy || exp_q.size() != 0 || done_cnt != 0) && n < budget) begin
      tick();
      n++;
    end
    chk("idle_reached", o_busy, 0);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic wait_starts(input int target, input int budget);
    int n = 0;
    while (starts_seen < target && n < budget) begin
      tick();
      n++;
    end
    chk("starts_reached", 32'(starts_seen >= target), 1);
  endtask

  task automatic do_reset(input logic with_valid);
    exp_q.delete();
    done_cnt       = 0;
    start_armed    = 1'b1;
    expect_chain   = 1'b0;
    i_reset        = 1'b1;
    i_result       = 16'h7777;
    i_result_valid = with_valid;
    tick();
    i_reset = 1'b0;
    chk("rst_busy", o_busy, 0);
    chk("rst_tx_start", o_tx_start, 0);
    chk("rst_tx_data", o_tx_data, 8'h00);
    chk("rst_frame_done", o_frame_done, 0);
    chk("rst_overflow", o_overflow, 0);
  endtask

  initial begin
    int base_starts;
    int base_frames;
    i_reset        = 1'b1;
    i_result       = '0;
    i_result_valid = 1'b0;
    i_tx_done      = 1'b0;
    tick();
    do_reset(1'b0);

    // Basic frame 1234 -> A5 34 12 83
    base_frames = frames;
    push_frame(16'h1234);
    send(16'h1234);
    wait_idle(300);
    chk("one_frame_done", frames - base_frames, 1);

    // All-zero result, start exactly one cycle after valid
    push_frame(16'h0000);
    send(16'h0000);
    chk("start_latency", o_tx_start, 1);
    chk("first_byte_header", o_tx_data, 8'hA5);
    wait_idle(300);

    // Back-to-back: second result during byte 2, no IDLE gap
    base_frames = frames;
    base_starts = starts_seen;
    push_frame(16'h1234);
    send(16'h1234);
    wait_starts(base_starts + 2, 100);
    push_frame(16'hFFFF);
    send(16'hFFFF);
    expect_chain = 1'b1;
    wait_idle(400);
    chk("chain_two_frames", frames - base_frames, 2);
    chk("chain_no_overflow", o_overflow, 0);
    chk("chain_flag_consumed", expect_chain, 0);

    // Three results in one frame: third dropped, overflow sticky
    base_frames = frames;
    push_frame(16'h1234);
    send(16'h1234);
    tick();
    push_frame(16'h5678);
    send(16'h5678);
    tick();
    send(16'h9ABC);
    chk("overflow_set", o_overflow, 1);
    wait_idle(500);
    chk("overflow_two_frames", frames - base_frames, 2);
    chk("overflow_sticky", o_overflow, 1);

    // Reset mid-frame, valid coincident with reset discarded
    base_starts = starts_seen;
    push_frame(16'h1234);
    send(16'h1234);
    wait_starts(base_starts + 2, 100);
    do_reset(1'b1);
    tick();
    chk("rst_valid_discarded", o_busy, 0);
    base_starts = starts_seen;
    i_tx_done = 1'b1;
    tick();
    repeat (5) tick();
    chk("stray_done_no_start", starts_seen - base_starts, 0);
    push_frame(16'hABCD);
    send(16'hABCD);
    wait_idle(300);

    // i_tx_done in IDLE and in START is ignored
    base_starts = starts_seen;
    i_tx_done = 1'b1;
    tick();
    repeat (4) tick();
    chk("idle_done_ignored", starts_seen - base_starts, 0);
    base_starts = starts_seen;
    inject_in_start = 1'b1;
    push_frame(16'h5A3C);
    send(16'h5A3C);
    wait_idle(300);
    chk("start_done_no_extra", starts_seen - base_starts, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_tx_framer.md
RESULT_TX_FRAMER -- requirements
Module: result_tx_framer

Interface
REQ-001 Parameter NB_RESULT, default 16: width of the ALU result; SHALL be a multiple of 8 in the range 8..32.
REQ-002 Parameter HEADER, default 8'hA5: first byte of every frame.
REQ-003 Port i_clk  input  1: the single clock; all logic SHALL be on its rising edge.
REQ-004 Port i_reset  input  1: synchronous, active-high reset.
REQ-005 Port i_result  input  NB_RESULT: ALU result; sampled only when i_result_valid=1.
REQ-006 Port i_result_valid  input  1: one-cycle pulse, result ready.
REQ-007 Port i_tx_done  input  1: one-cycle pulse from the UART transmitter when a byte's stop bit completes.
REQ-008 Port o_tx_start  output  1: one-cycle pulse requesting transmission of o_tx_data.
REQ-009 Port o_tx_data  output  8: byte to transmit.
REQ-010 Port o_busy  output  1: high whenever the block is not in IDLE.
REQ-011 Port o_frame_done  output  1: one-cycle pulse after the last byte of a frame completes.
REQ-012 Port o_overflow  output  1: sticky; a result was dropped.

Function
REQ-013 Frame order SHALL be: HEADER, result bytes LSB first (NB_RESULT/8 bytes), then checksum = XOR of HEADER and all result bytes.
REQ-014 FSM states SHALL be IDLE, START, WAIT, DONE.
REQ-015 IDLE: on i_result_valid in cycle t, capture i_result and enter START; o_tx_start=1 with o_tx_data=HEADER in cycle t+1.
REQ-016 START lasts exactly one cycle (o_tx_start=1), then WAIT.
REQ-017 WAIT: o_tx_data SHALL stay stable; on i_tx_done, advance the byte index and enter START next cycle, or enter DONE after the checksum byte.
REQ-018 DONE lasts one cycle with o_frame_done=1; then START with HEADER if the pending buffer is full (buffer moved to the active register), else IDLE.
REQ-019 i_tx_done outside WAIT SHALL be ignored.
REQ-020 Pending buffer is one entry: i_result_valid while o_busy=1 SHALL be captured if the buffer is empty, including in the DONE cycle.
REQ-021 i_result_valid while o_busy=1 with the buffer full SHALL drop the result and set o_overflow=1 until reset.
REQ-022 Byte index SHALL count 0..NB_RESULT/8+1 and SHALL clear on every new frame.
REQ-023 The checksum SHALL be accumulated or computed from the captured result, never from the live i_result.
REQ-024 o_tx_start SHALL never assert twice without an intervening i_tx_done.

Reset
REQ-025 When i_reset=1 at a clock edge, the following SHALL hold next cycle: FSM=IDLE, byte index=0, pending buffer empty, o_tx_start=0, o_tx_data=8'h00, o_busy=0, o_frame_done=0, o_overflow=0.
REQ-026 Reset mid-frame SHALL abandon the frame; a stray i_tx_done afterwards SHALL be ignored.
REQ-027 i_result_valid coincident with reset SHALL be discarded.

Structure
REQ-028 The shared package uart_alu_pkg SHALL hold the FSM state encoding, the default HEADER constant and the byte-count function NB_RESULT/8.
REQ-029 Single module, no sub-module.
REQ-030 The block SHALL sit between the ALU output and the UART transmitter inputs (i_tx_start/i_data); the transmitter's done pulse feeds i_tx_done.

Verification
REQ-031 Send i_result=16'h1234 with a tx model returning done 10 cycles after each start -> bytes A5,34,12,83, then one o_frame_done pulse and o_busy=0.
REQ-032 Send i_result=16'h0000 -> bytes A5,00,00,A5; o_tx_start first high exactly one cycle after i_result_valid.
REQ-033 Send 16'h1234, then 16'hFFFF during byte 2 -> the first frame completes, and the next frame A5,FF,FF,A5 starts the cycle after o_frame_done with no IDLE gap; o_overflow=0.
REQ-034 Send three results during one frame -> the third is dropped, o_overflow=1 and stays set; only two frames are transmitted.
REQ-035 Reset after two bytes, then a stray i_tx_done, then send 16'hABCD -> no start on the stray done; frame A5,CD,AB,C3.
REQ-036 Pulse i_tx_done during START and during IDLE -> no byte advance and no extra o_tx_start.
